// File: rtl/bram_port_arb_pkg.sv
// Shared constants for the two-requester BRAM port arbiter.
package bram_port_arb_pkg;

    localparam int N_DEF     = 8;
    localparam int B_DEF     = 16;
    localparam int BURST_DEF = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bram_port_arb_if.sv
// Requester handshakes, responses and the RAM port of the BRAM arbiter.
interface bram_port_arb_if
    import bram_port_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int B = B_DEF
);
    logic         req0_valid;
    logic         req0_ready;
    logic         req0_we;
    logic [N-1:0] req0_addr;
    logic [B-1:0] req0_wdata;
    logic         req1_valid;
    logic         req1_ready;
    logic         req1_we;
    logic [N-1:0] req1_addr;
    logic [B-1:0] req1_wdata;
    logic         rsp0_valid;
    logic [B-1:0] rsp0_rdata;
    logic         rsp1_valid;
    logic [B-1:0] rsp1_rdata;
    logic         ram_en;
    logic         ram_we;
    logic         ram_re;
    logic [N-1:0] ram_addr;
    logic [B-1:0] ram_di;
    logic [B-1:0] ram_do;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_do,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  ram_en, ram_we, ram_re, ram_addr, ram_di
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_do,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output ram_en, ram_we, ram_re, ram_addr, ram_di
    );
endinterface

// File: rtl/bram_rr_grant.sv
// Burst-limited grant selection between two requesters.
// cnt==0 only follows reset: no burst is running, so the non-owner (req0) wins.
module bram_rr_grant
    import bram_port_arb_pkg::*;
#(
    parameter  int BURST = BURST_DEF,
    localparam int CW    = $clog2(BURST + 1)
) (
    input  logic [1:0]    valid,
    input  logic          owner,
    input  logic [CW-1:0] cnt,
    output logic [1:0]    grant
);

    logic keep_s;

    // Pick the requester that may issue this cycle.
    always_comb begin
        grant  = 2'b00;
        keep_s = (cnt != CW'(0)) && (cnt < CW'(BURST));
        case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (keep_s) begin
                    grant = (owner == REQ1) ? 2'b10 : 2'b01;
                end else begin
                    grant = (owner == REQ1) ? 2'b01 : 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bram_port_arb.sv
// Arbitrates two requesters onto one registered-read BRAM port and routes
// read data back to the issuer one cycle later.
module bram_port_arb
    import bram_port_arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int B     = B_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    bram_port_arb_if.slave bus
);

    localparam int CW = $clog2(BURST + 1);

    logic          owner_r;
    logic [CW-1:0] cnt_r;
    logic          pend_r;
    logic          tag_r;
    logic [N-1:0]  addr_r;
    logic [B-1:0]  di_r;

    logic [1:0]    valid_s;
    logic [1:0]    grant_s;
    logic          issue_s;
    logic          sel_s;
    logic          we_s;
    logic [N-1:0]  addr_s;
    logic [B-1:0]  di_s;

    assign valid_s = {bus.req1_valid, bus.req0_valid};

    bram_rr_grant #(.BURST(BURST)) u_grant (
        .valid (valid_s),
        .owner (owner_r),
        .cnt   (cnt_r),
        .grant (grant_s)
    );

    // Handshake and issue mux; readies are held low while reset is asserted.
    always_comb begin
        bus.req0_ready = rst_n & grant_s[0];
        bus.req1_ready = rst_n & grant_s[1];
        issue_s        = bus.req0_ready | bus.req1_ready;
        sel_s          = bus.req1_ready;
        if (sel_s == REQ1) begin
            we_s   = bus.req1_we;
            addr_s = bus.req1_addr;
            di_s   = bus.req1_wdata;
        end else begin
            we_s   = bus.req0_we;
            addr_s = bus.req0_addr;
            di_s   = bus.req0_wdata;
        end
        bus.ram_en   = issue_s;
        bus.ram_we   = issue_s & we_s;
        bus.ram_re   = issue_s & ~we_s;
        bus.ram_addr = issue_s ? addr_s : addr_r;
        bus.ram_di   = issue_s ? di_s : di_r;
    end

    // Ownership, burst count, held RAM address/data and the read-return tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_r <= REQ1;
            cnt_r   <= CW'(0);
            pend_r  <= 1'b0;
            tag_r   <= REQ0;
            addr_r  <= N'(0);
            di_r    <= B'(0);
        end else begin
            pend_r <= issue_s & ~we_s;
            if (issue_s) begin
                tag_r  <= sel_s;
                addr_r <= addr_s;
                di_r   <= di_s;
                if (sel_s == owner_r) begin
                    cnt_r <= (cnt_r == CW'(BURST)) ? cnt_r : cnt_r + CW'(1);
                end else begin
                    owner_r <= sel_s;
                    cnt_r   <= CW'(1);
                end
            end else begin
                tag_r <= tag_r;
            end
        end
    end

    // Response steering; a read pending across reset assertion is suppressed.
    always_comb begin
        bus.rsp0_valid = rst_n & pend_r & (tag_r == REQ0);
        bus.rsp1_valid = rst_n & pend_r & (tag_r == REQ1);
        bus.rsp0_rdata = bus.rsp0_valid ? bus.ram_do : B'(0);
        bus.rsp1_rdata = bus.rsp1_valid ? bus.ram_do : B'(0);
    end

endmodule

// File: tb/tb_bram_port_arb.sv
// Directed scenarios plus a cycle-level arbitration model and read scoreboard.
module tb_bram_port_arb;
    import bram_port_arb_pkg::*;

    localparam int N     = 8;
    localparam int B     = 16;
    localparam int BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bram_port_arb_if #(.N(N), .B(B)) bus ();

    bram_port_arb #(.N(N), .B(B), .BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [B-1:0] mem     [0:255];
    logic [B-1:0] ref_mem [0:255];

    // Registered-read BRAM model behind the arbiter port.
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
        if (bus.ram_en && bus.ram_re) bus.ram_do <= mem[bus.ram_addr];
    end

    typedef struct {
        bit           tag;
        logic [B-1:0] data;
    } rsp_t;
    rsp_t q[$];

    bit           owner_m;
    int           cnt_m;
    logic [N-1:0] last_addr_m;
    logic [B-1:0] last_di_m;

    // Reference arbiter and response scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin : monitor
        rsp_t         e;
        bit           ev0, ev1, g0, g1, sel;
        logic         we;
        logic [N-1:0] a;
        logic [B-1:0] d, x0, x1;
        ev0 = 1'b0; ev1 = 1'b0; e.tag = 1'b0; e.data = '0;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (rst_n) begin
                ev0 = !e.tag;
                ev1 = e.tag;
            end
        end
        x0 = ev0 ? e.data : 16'h0000;
        x1 = ev1 ? e.data : 16'h0000;
        checks++;
        if (bus.rsp0_valid !== ev0 || bus.rsp1_valid !== ev1 ||
            bus.rsp0_rdata !== x0 || bus.rsp1_rdata !== x1) begin
            errors++;
            $display("FAIL sb_rsp: got v0=%0b d0=%h v1=%0b d1=%h, expected v0=%0b d0=%h v1=%0b d1=%h",
                     bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata, ev0, x0, ev1, x1);
        end
        if (!rst_n) begin
            checks++;
            if ({bus.req1_ready, bus.req0_ready, bus.ram_en, bus.ram_we, bus.ram_re} !== 5'b00000) begin
                errors++;
                $display("FAIL sb_reset_quiet: got rdy1/rdy0/en/we/re=%b, expected 00000",
                         {bus.req1_ready, bus.req0_ready, bus.ram_en, bus.ram_we, bus.ram_re});
            end
            owner_m = 1'b1; cnt_m = 0; last_addr_m = '0; last_di_m = '0;
            q.delete();
        end else begin
            g0 = 1'b0; g1 = 1'b0;
            if (bus.req0_valid && !bus.req1_valid) g0 = 1'b1;
            else if (bus.req1_valid && !bus.req0_valid) g1 = 1'b1;
            else if (bus.req0_valid && bus.req1_valid) begin
                sel = (cnt_m > 0 && cnt_m < BURST) ? owner_m : !owner_m;
                g0 = !sel; g1 = sel;
            end
            checks++;
            if (bus.req0_ready !== g0 || bus.req1_ready !== g1) begin
                errors++;
                $display("FAIL sb_grant: got ready0=%0b ready1=%0b, expected %0b %0b",
                         bus.req0_ready, bus.req1_ready, g0, g1);
            end
            if (g0 || g1) begin
                sel = g1;
                we  = sel ? bus.req1_we : bus.req0_we;
                a   = sel ? bus.req1_addr : bus.req0_addr;
                d   = sel ? bus.req1_wdata : bus.req0_wdata;
                checks++;
                if (bus.ram_en !== 1'b1 || bus.ram_we !== we || bus.ram_re !== !we ||
                    bus.ram_addr !== a || bus.ram_di !== d) begin
                    errors++;
                    $display("FAIL sb_issue: got en=%0b we=%0b re=%0b addr=%h di=%h, expected 1 %0b %0b %h %h",
                             bus.ram_en, bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_di, we, !we, a, d);
                end
                if (!we) q.push_back('{sel, ref_mem[a]});
                else     ref_mem[a] = d;
                if (sel == owner_m) begin
                    if (cnt_m < BURST) cnt_m++;
                end else begin
                    owner_m = sel; cnt_m = 1;
                end
                last_addr_m = a; last_di_m = d;
            end else begin
                checks++;
                if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0 ||
                    bus.ram_addr !== last_addr_m || bus.ram_di !== last_di_m) begin
                    errors++;
                    $display("FAIL sb_idle: got en=%0b we=%0b re=%0b addr=%h di=%h, expected 0 0 0 %h %h",
                             bus.ram_en, bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_di, last_addr_m, last_di_m);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit v, input bit we, input logic [N-1:0] a, input logic [B-1:0] d);
        bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    endtask

    task automatic drive1(input bit v, input bit we, input logic [N-1:0] a, input logic [B-1:0] d);
        bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive0(1'b1, 1'b0, 8'h03, 16'h0000);
        drive1(1'b1, 1'b0, 8'h04, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.ram_en !== 1'b0 ||
                bus.ram_addr !== 8'h00 || bus.ram_di !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state: got rdy0=%0b rdy1=%0b en=%0b addr=%h di=%h, expected 0 0 0 00 0000",
                         bus.req0_ready, bus.req1_ready, bus.ram_en, bus.ram_addr, bus.ram_di);
            end
        end
        cyc();
        rst_n = 1'b1;
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.ram_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_issue: got ready0=%0b en=%0b, expected 1 1", bus.req0_ready, bus.ram_en);
        end
        cyc();
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        cyc();
    endtask

    task automatic test_write_read();
        drive0(1'b1, 1'b1, 8'h05, 16'hABCD);
        cyc();
        drive0(1'b1, 1'b0, 8'h05, 16'h0000);
        cyc();
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 16'hABCD || bus.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_read: got v0=%0b d0=%h v1=%0b, expected 1 abcd 0",
                     bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid);
        end
        cyc();
    endtask

    task automatic test_contention();
        bit pat [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        drive0(1'b1, 1'b0, 8'h10, 16'h0000);
        drive1(1'b1, 1'b0, 8'h20, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req0_ready !== pat[i] || bus.req1_ready !== !pat[i]) begin
                errors++;
                $display("FAIL contention[%0d]: got ready0=%0b ready1=%0b, expected %0b %0b",
                         i, bus.req0_ready, bus.req1_ready, pat[i], !pat[i]);
            end
            cyc();
        end
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        cyc();
    endtask

    task automatic test_solo1();
        int issues = 0;
        for (int i = 0; i < 10; i++) begin
            drive1(1'b1, 1'b0, 8'(8'h40 + i), 16'h0000);
            @(negedge clk);
            if (bus.req1_ready === 1'b1 && bus.req0_ready === 1'b0) issues++;
            cyc();
        end
        checks++;
        if (issues !== 10) begin
            errors++;
            $display("FAIL solo1_issues: got %0d, expected 10", issues);
        end
        drive0(1'b1, 1'b0, 8'h50, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL solo1_switch: got ready0=%0b ready1=%0b, expected 1 0", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        cyc();
    endtask

    task automatic test_alternate();
        mem[1] = 16'h0011; ref_mem[1] = 16'h0011;
        mem[2] = 16'h0022; ref_mem[2] = 16'h0022;
        drive0(1'b1, 1'b0, 8'h01, 16'h0000);
        cyc();
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        drive1(1'b1, 1'b0, 8'h02, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 16'h0011 || bus.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_rsp0: got v0=%0b d0=%h v1=%0b, expected 1 0011 0",
                     bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid);
        end
        cyc();
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_rdata !== 16'h0022 || bus.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_rsp1: got v1=%0b d1=%h v0=%0b, expected 1 0022 0",
                     bus.rsp1_valid, bus.rsp1_rdata, bus.rsp0_valid);
        end
        cyc();
    endtask

    task automatic test_reset_drop();
        drive0(1'b1, 1'b0, 8'h05, 16'h0000);
        cyc();
        rst_n = 1'b0;
        drive1(1'b1, 1'b0, 8'h06, 16'h0000);
        @(negedge clk);
        checks++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.ram_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got v0=%0b v1=%0b en=%0b, expected 0 0 0",
                     bus.rsp0_valid, bus.rsp1_valid, bus.ram_en);
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_grant: got ready0=%0b ready1=%0b, expected 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        cyc();
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic test_idle();
        drive1(1'b1, 1'b1, 8'h77, 16'h1234);
        cyc();
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        drive0(1'b0, 1'b1, 8'h11, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ram_en !== 1'b0 || bus.ram_addr !== 8'h77 || bus.ram_di !== 16'h1234) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got en=%0b addr=%h di=%h, expected 0 77 1234",
                         i, bus.ram_en, bus.ram_addr, bus.ram_di);
            end
            if (i >= 1) begin
                checks++;
                if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_rsp[%0d]: got v0=%0b v1=%0b, expected 0 0",
                             i, bus.rsp0_valid, bus.rsp1_valid);
                end
            end
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        test_reset();
        test_write_read();
        test_contention();
        test_solo1();
        test_alternate();
        test_reset_drop();
        test_idle();
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
